// File: rtl/ram_bist_if.sv
// RAM port bundle between the BIST initiator and a dual-port RAM.
// The master drives the write port and the read address. The slave (the RAM)
// returns registered read data one cycle after address_read.
interface ram_bist_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
);
    logic [A_WIDTH-1:0] address_write;
    logic [D_WIDTH-1:0] data_write;
    logic               write_enable;
    logic [A_WIDTH-1:0] address_read;
    logic [D_WIDTH-1:0] data_read;

    modport master (
        output address_write,
        output data_write,
        output write_enable,
        output address_read,
        input  data_read
    );

    modport slave (
        input  address_write,
        input  data_write,
        input  write_enable,
        input  address_read,
        output data_read
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: 4-phase march test initiator for a dual-port RAM.
// Phases: write pat(a), read/check pat(a), write ~pat(a), read/check ~pat(a),
// where pat(a) = PATTERN ^ zero-extended a.
// Optional build macro RAM_BIST_STOP_ON_FAIL_EN: the first mismatch ends the
// test at the next edge (err_count=1, pass=0) with no further RAM accesses.
module ram_bist_ctrl #(
    parameter int                 D_WIDTH = 16,
    parameter int                 A_WIDTH = 5,
    parameter logic [D_WIDTH-1:0] PATTERN = 16'hA5A5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [A_WIDTH+1:0] err_count,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [D_WIDTH-1:0] fail_data,
    ram_bist_if.master         ram
);

    localparam logic [A_WIDTH-1:0] ADDR_LAST = {A_WIDTH{1'b1}};
    localparam logic [A_WIDTH+1:0] ERR_MAX   = {(A_WIDTH+2){1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Test pattern for address a; inv selects the inverse (second half) pass.
    function automatic logic [D_WIDTH-1:0] f_pat(input logic [A_WIDTH-1:0] a, input logic inv);
        logic [D_WIDTH-1:0] p;
        p = PATTERN ^ D_WIDTH'(a);
        return inv ? ~p : p;
    endfunction

    state_t             r_state;
    logic [A_WIDTH-1:0] r_addr;       // address currently presented to the RAM
    logic               r_tail;       // read phase is in its extra check cycle
    logic               r_vld;        // data_read holds the word for r_chk_addr
    logic [A_WIDTH-1:0] r_chk_addr;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [A_WIDTH+1:0] r_err;
    logic [A_WIDTH-1:0] r_fail_addr;
    logic [D_WIDTH-1:0] r_fail_data;
    logic [A_WIDTH-1:0] r_aw;
    logic [D_WIDTH-1:0] r_dw;
    logic               r_we;
    logic [A_WIDTH-1:0] r_ar;

    logic [D_WIDTH-1:0] w_exp;
    logic               w_mis;
    logic               w_stop;
    logic [A_WIDTH+1:0] w_err_nxt;

    // Compare returning read data with the expected pattern and form the next error count.
    always_comb begin
        w_exp = f_pat(r_chk_addr, (r_state == S_RD1));
        if (r_vld && ((r_state == S_RD0) || (r_state == S_RD1))) begin
            w_mis = (ram.data_read != w_exp);
        end else begin
            w_mis = 1'b0;
        end
        if (w_mis && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + (A_WIDTH+2)'(1);
        end else begin
            w_err_nxt = r_err;
        end
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        w_stop = w_mis;
`else
        w_stop = 1'b0;
`endif
    end

    // March sequencer with registered RAM controls and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_tail      <= 1'b0;
            r_vld       <= 1'b0;
            r_chk_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_aw        <= '0;
            r_dw        <= '0;
            r_we        <= 1'b0;
            r_ar        <= '0;
        end else begin
            // Error accounting; err_count==0 identifies the first mismatch since start.
            if (w_mis) begin
                r_err <= w_err_nxt;
                if (r_err == '0) begin
                    r_fail_addr <= r_chk_addr;
                    r_fail_data <= ram.data_read;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WR0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err       <= '0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                        r_addr      <= '0;
                        r_tail      <= 1'b0;
                        r_vld       <= 1'b0;
                        r_we        <= 1'b1;
                        r_aw        <= '0;
                        r_dw        <= f_pat('0, 1'b0);
                    end else begin
                        r_state <= r_state;
                    end
                end

                S_WR0, S_WR1: begin
                    if (r_addr == ADDR_LAST) begin
                        // Last write commits at this edge; reads start at address 0 with no bubble.
                        r_state <= (r_state == S_WR0) ? S_RD0 : S_RD1;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_ar    <= '0;
                        r_tail  <= 1'b0;
                        r_vld   <= 1'b0;
                    end else begin
                        r_addr <= r_addr + A_WIDTH'(1);
                        r_aw   <= r_addr + A_WIDTH'(1);
                        r_dw   <= f_pat(r_addr + A_WIDTH'(1), (r_state == S_WR1));
                    end
                end

                S_RD0, S_RD1: begin
                    if (w_stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_vld   <= 1'b0;
                    end else if (!r_tail) begin
                        r_vld      <= 1'b1;
                        r_chk_addr <= r_addr;
                        if (r_addr == ADDR_LAST) begin
                            r_tail <= 1'b1;
                        end else begin
                            r_addr <= r_addr + A_WIDTH'(1);
                            r_ar   <= r_addr + A_WIDTH'(1);
                        end
                    end else begin
                        // Extra cycle has checked the last address; move on.
                        r_vld  <= 1'b0;
                        r_tail <= 1'b0;
                        r_addr <= '0;
                        if (r_state == S_RD0) begin
                            r_state <= S_WR1;
                            r_we    <= 1'b1;
                            r_aw    <= '0;
                            r_dw    <= f_pat('0, 1'b1);
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign pass              = r_pass;
    assign err_count         = r_err;
    assign fail_addr         = r_fail_addr;
    assign fail_data         = r_fail_data;
    assign ram.address_write = r_aw;
    assign ram.data_write    = r_dw;
    assign ram.write_enable  = r_we;
    assign ram.address_read  = r_ar;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural dual-port RAM with per-address
// stuck-at masks, a directed table of fault cases, randomized fault runs
// checked against a march-test reference model, plus reset corner cases.
module tb_ram_bist_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW+1:0] err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    ram_bist_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    ram_bist_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .PATTERN(16'hA5A5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .ram       (bus)
    );

    always #5 clk = ~clk;

    // RAM model: stuck-at-0 / stuck-at-1 masks applied to stored data, registered read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s0  [DEPTH];
    logic [DW-1:0] s1  [DEPTH];

    always @(posedge clk) begin
        if (bus.write_enable)
            mem[bus.address_write] <= (bus.data_write & ~s0[bus.address_write]) | s1[bus.address_write];
        bus.data_read <= mem[bus.address_read];
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: march over both phases using the fault masks.
    function automatic void model(output int err, output int fa, output int fd,
                                  output int busyc, output int wec);
        err = 0; fa = 0; fd = 0;
        busyc = 4 * DEPTH + 2;
        wec   = 2 * DEPTH;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [15:0] w;
                logic [15:0] st;
                w = 16'hA5A5 ^ 16'(a);
                if (ph == 1) w = ~w;
                st = (w & ~s0[a]) | s1[a];
                if (st != w) begin
                    if (err == 0) begin
                        fa = a;
                        fd = int'(st);
                        if (STOP) begin
                            err   = 1;
                            busyc = ((ph == 0) ? DEPTH : 3 * DEPTH + 1) + a + 2;
                            wec   = (ph == 0) ? DEPTH : 2 * DEPTH;
                            return;
                        end
                    end
                    if (err < 127) err++;
                end
            end
        end
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s0[a] = 16'h0000;
            s1[a] = 16'h0000;
        end
    endtask

    // One run from a start pulse to done; counts busy/write_enable cycles and checks the wrap.
    task automatic run_one(input string nm, input int restart, output int busyc, output int wec);
        int  n;
        bit  prev_last;
        bit  wrap_seen;
        busyc = 0; wec = 0; n = 0; prev_last = 1'b0; wrap_seen = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 400) begin
            if (busy) busyc++;
            if (bus.write_enable) wec++;
            if (prev_last && !wrap_seen) begin
                wrap_seen = 1'b1;
                check({nm, "_wrap"}, {58'd0, bus.address_read, bus.write_enable}, 64'd0);
            end
            prev_last = bus.write_enable && (bus.address_write == 5'd31);
            start = (restart >= 0 && busyc == restart) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({nm, "_timeout"}, {63'd0, done}, 64'd1);
    endtask

    task automatic run_and_check(input string nm, input int restart, input int e_err, input int e_fa,
                                 input int e_fd, input int e_busy, input int e_we, input bit e_pass);
        int bc, wc;
        run_one(nm, restart, bc, wc);
        check({nm, "_busy"},  64'(bc), 64'(e_busy));
        check({nm, "_we"},    64'(wc), 64'(e_we));
        check({nm, "_done"},  {63'd0, done}, 64'd1);
        check({nm, "_pass"},  {63'd0, pass}, {63'd0, e_pass});
        check({nm, "_err"},   {57'd0, err_count}, 64'(e_err));
        check({nm, "_faddr"}, {59'd0, fail_addr}, 64'(e_fa));
        check({nm, "_fdata"}, {48'd0, fail_data}, 64'(e_fd));
    endtask

    typedef struct {
        string       name;
        int          faddr;     // -1: masks applied to every address
        logic [15:0] m0;
        logic [15:0] m1;
        int          restart;   // busy sample at which start is re-pulsed, -1 none
        int          e_err;
        int          e_fa;
        int          e_fd;
        int          e_busy;
        int          e_we;
        bit          e_pass;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"ideal",   0, 16'h0000, 16'h0000, -1, 0, 0, 0, 130, 64, 1'b1};
        vecs[1] = '{"s0a5b0",  5, 16'h0001, 16'h0000, -1, 1, 5, 32'h5A5E, STOP ? 104 : 130, 64, 1'b0};
        vecs[2] = '{"restart", 0, 16'h0000, 16'h0000, 40, 0, 0, 0, 130, 64, 1'b1};
        vecs[3] = '{"s0a3b7",  3, 16'h0080, 16'h0000, -1, 1, 3, 32'hA526, STOP ? 37 : 130, STOP ? 32 : 64, 1'b0};
        vecs[4] = '{"all1",   -1, 16'h0000, 16'hFFFF, -1, STOP ? 1 : 64, 0, 32'hFFFF,
                    STOP ? 34 : 130, STOP ? 32 : 64, 1'b0};

        clear_faults();
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, pass, err_count, fail_addr, fail_data,
                             bus.address_write, bus.data_write, bus.write_enable, bus.address_read}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outs", {61'd0, busy, done, bus.write_enable}, 64'd0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            clear_faults();
            if (vecs[i].faddr < 0) begin
                for (int a = 0; a < DEPTH; a++) begin
                    s0[a] = vecs[i].m0;
                    s1[a] = vecs[i].m1;
                end
            end else begin
                s0[vecs[i].faddr] = vecs[i].m0;
                s1[vecs[i].faddr] = vecs[i].m1;
            end
            run_and_check(vecs[i].name, vecs[i].restart, vecs[i].e_err, vecs[i].e_fa, vecs[i].e_fd,
                          vecs[i].e_busy, vecs[i].e_we, vecs[i].e_pass);
            repeat (2) @(negedge clk);
        end

        // Randomized single-bit stuck faults against the reference model
        for (int r = 0; r < 6; r++) begin
            int k, e_err, e_fa, e_fd, e_busy, e_we;
            clear_faults();
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                int          a;
                logic [15:0] bitm;
                a    = $urandom_range(0, DEPTH - 1);
                bitm = 16'h0001 << $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 0) s0[a] = s0[a] | bitm;
                else                           s1[a] = s1[a] | bitm;
            end
            model(e_err, e_fa, e_fd, e_busy, e_we);
            run_and_check($sformatf("rand%0d", r), -1, e_err, e_fa, e_fd, e_busy, e_we, (e_err == 0));
            repeat (1) @(negedge clk);
        end

        // Asynchronous reset in the middle of the inverse write phase
        clear_faults();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (69) @(negedge clk);
        check("mid_wr1_we", {63'd0, bus.write_enable}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {busy, done, pass, err_count, fail_addr, fail_data,
                               bus.address_write, bus.data_write, bus.write_enable, bus.address_read}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_and_check("after_rst", -1, 0, 0, 0, 130, 64, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
